spi_slave_cpol_cpha: RTL

SPI responder (slave) for the SPI initiator in the same design, supporting all four CPOL/CPHA modes, MSB first. It samples sclk/cs/mosi oversampled in the system clk domain and shifts a DATA_W-bit word in on mosi while shifting a word out on miso. It exposes a valid/ready transmit holding register and a one-cycle receive strobe to local logic.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_cpol_cpha.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Mode encoding is {cpol, cpha}.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_DATA_W = 8;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Modes with cpha=0 sample on the leading sclk edge, cpha=1 on the trailing one.
    function automatic logic sample_on_leading(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE2);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a history flop,
// giving the synchronized level plus single-cycle rise/fall strobes.
// RST_VAL is the level assumed after reset; an edge from that value is only
// reported once the pin actually differs from it.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain and one-cycle-old copy of the synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave_cpol_cpha.sv
// SPI responder, all four CPOL/CPHA modes, MSB first, oversampled in clk.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds frame_err and
// tx_underrun strobes; without it those ports and their logic do not exist.
// sclk half-period must be at least SYNC_STAGES+2 clk cycles.
module spi_slave_cpol_cpha
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              frame_err,
    output logic              tx_underrun,
`endif
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    // Reset value 0 on cs means a frame already in progress when reset is
    // released produces no cs fall; only a fresh falling edge starts a frame.
    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level_unused, cs_rise, cs_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (sclk),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (cs),
        .level_o (cs_level_unused),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // mosi only needs its level; same depth as sclk so data and clock stay aligned.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    // Level-only synchronizer for mosi.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge classification
    // ------------------------------------------------------------------
    // Leading edge: sclk leaves its idle (cpol) level; trailing: returns to it.
    logic sclk_edge, lead_edge, trail_edge, sample_lead, sample_edge, shift_edge;

    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_level != cpol);
    assign trail_edge  = sclk_edge & (sclk_level == cpol);
    assign sample_lead = sample_on_leading({cpol, cpha});
    assign sample_edge = sample_lead ? lead_edge  : trail_edge;
    assign shift_edge  = sample_lead ? trail_edge : lead_edge;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: cs fall opens a frame, cs rise closes it at any point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: miso is driven for the whole frame.
    always_comb begin
        busy    = (state_q == ACTIVE);
        miso_oe = (state_q == ACTIVE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic              start_frame, end_frame, in_frame, do_sample, do_shift;
    logic              tx_load, tx_write;
    logic [DATA_W-1:0] load_word, rx_word;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, miso_d;
    logic              rx_valid_q, rx_valid_d;
    logic              word_done_q, word_done_d;

    assign start_frame = (state_q == IDLE) && cs_fall;
    assign end_frame   = (state_q == ACTIVE) && cs_rise;
    assign in_frame    = (state_q == ACTIVE) && !cs_rise;
    assign do_sample   = in_frame && sample_edge;
    assign do_shift    = in_frame && shift_edge;

    // A new word is loaded at frame start and on the first shift edge after a
    // completed word; an empty holding register loads zeros (underrun).
    assign tx_load   = start_frame || (do_shift && word_done_q);
    assign tx_write  = tx_valid && tx_ready;
    assign load_word = hold_full_q ? hold_q : '0;
    assign rx_word   = {rx_shift_q, mosi_s};

    // Shift/count next-state logic.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        word_done_d = word_done_q;
        rx_valid_d  = 1'b0;
        if (start_frame) begin
            tx_shift_d  = load_word;
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
            // cpha=0: first bit must be on the wire before the first edge.
            if (!cpha) miso_d = load_word[DATA_W-1];
        end else if (end_frame) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
            miso_d      = 1'b0;
        end else if (do_sample) begin
            rx_shift_d = rx_word[DATA_W-2:0];
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d   = '0;
                rx_data_d   = rx_word;
                rx_valid_d  = 1'b1;
                word_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (do_shift) begin
            if (word_done_q) begin
                tx_shift_d  = load_word;
                miso_d      = load_word[DATA_W-1];
                word_done_d = 1'b0;
            end else if (bit_cnt_q != '0) begin
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                miso_d     = tx_shift_q[DATA_W-2];
            end else begin
                // cpha=1: first leading edge of the frame presents the MSB.
                miso_d = tx_shift_q[DATA_W-1];
            end
        end
    end

    // Holding register: a write fills it, a load empties it unless refilled
    // in the same cycle.
    always_comb begin
        hold_d      = tx_write ? tx_data : hold_q;
        hold_full_d = (hold_full_q && !tx_load) || tx_write;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;
    logic tx_underrun_q, tx_underrun_d;

    // Abort with a partial word, and a load from an empty holding register.
    always_comb begin
        frame_err_d   = end_frame && (bit_cnt_q != '0);
        tx_underrun_d = tx_load && !hold_full_q;
    end

    // Error strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_err_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign frame_err   = frame_err_q;
    assign tx_underrun = tx_underrun_q;
`endif

endmodule
